// File: rtl/lfsr_prng_pkg.sv
// Shared types, constants and the single-shift helper for the LFSR PRNG.
package lfsr_prng_pkg;

  // Widest state the helper supports; narrower states are zero-extended.
  localparam int unsigned LFSR_MAX_W = 256;

  // Operating phases: output is withheld during WARMUP, handshaken in RUN.
  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } state_e;

  // Maximal-length XNOR tap masks for common widths.
  localparam logic [7:0]   LFSR_TAPS_8   = 8'hB8;
  localparam logic [15:0]  LFSR_TAPS_16  = 16'hB400;
  localparam logic [31:0]  LFSR_TAPS_32  = 32'h8020_0003;
  localparam logic [127:0] LFSR_TAPS_128 = 128'h8000_0000_0000_0000_0008_0000_0000_2112;

  // One Fibonacci XNOR shift: feedback is the inverted parity of the tapped
  // bits, shifted in at bit 0. Tap bits above the real width must be zero so
  // the garbage shifted into the upper bits never reaches the feedback.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic fb;
    fb = ~^(s & taps);
    return (s << 1) | LFSR_MAX_W'(fb);
  endfunction

endpackage

// File: rtl/lfsr_prng_core.sv
// Combinational STEP-fold unrolling of the single-shift LFSR function.
module lfsr_prng_core
  import lfsr_prng_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] cur;

  // Apply the single shift STEP times back to back within one cycle.
  always_comb begin
    // NOTE: blocking assignments here are intentional -- each loop iteration
    // must see the value produced by the previous one, like a wire chain.
    cur = state_i;
    for (int i = 0; i < int'(STEP); i++) begin
      cur = WIDTH'(lfsr_step(LFSR_MAX_W'(cur), LFSR_MAX_W'(taps_i)));
    end
    state_o = cur;
  end

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci XNOR LFSR random source with loadable seed/taps,
// warm-up phase, valid/ready output handshake and all-ones lockup escape.
module lfsr_prng
  import lfsr_prng_pkg::*;
#(
  parameter int unsigned      WIDTH  = 128,
  parameter int unsigned      OUT_W  = 8,
  parameter int unsigned      STEP   = 1,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(LFSR_TAPS_128),
  parameter int unsigned      WARMUP = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [OUT_W-1:0] rnd_o,
  output logic [WIDTH-1:0] state_o,
  output logic             busy_o
);

  // A zero-length warm-up still needs a legal 1-bit counter; it is never used.
  localparam int unsigned      CNT_W      = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
  localparam logic             HAS_WARMUP = (WARMUP > 0);
  localparam state_e           FSM_INIT   = HAS_WARMUP ? ST_WARMUP : ST_RUN;

  // Forcing the top tap keeps the shift map bijective, so all-ones can only
  // ever map to itself and is never entered from any other state.
  localparam logic [WIDTH-1:0] TAP_MSB    = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] TAPS_INIT  = TAPS | TAP_MSB;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           fsm_q, fsm_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] stepped;
  logic             fire;
  logic             advance;

  lfsr_prng_core #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_core (
    .state_i (state_q),
    .taps_i  (taps_q),
    .state_o (stepped)
  );

  assign fire = valid_q & rnd_ready_i;

  // Next-state logic: seed load beats everything, then the warm-up/run phases.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    taps_d  = taps_q;
    cnt_d   = cnt_q;
    fsm_d   = fsm_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    advance = 1'b0;

    if (seed_valid_i) begin
      taps_d  = taps_i | TAP_MSB;
      cnt_d   = '0;
      fsm_d   = FSM_INIT;
      valid_d = ~HAS_WARMUP;
      busy_d  = HAS_WARMUP;
    end else begin
      unique case (fsm_q)
        ST_WARMUP: begin
          advance = 1'b1;
          if (cnt_q == CNT_LAST) begin
            fsm_d   = ST_RUN;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          advance = fire;
        end
        default: begin
          fsm_d = FSM_INIT;
        end
      endcase
    end

    // All-ones is a dead fixed point: never load it, and escape it if seen.
    if (seed_valid_i) begin
      state_d = (&seed_i) ? SEED : seed_i;
    end else if (&state_q) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = stepped;
    end else begin
      state_d = state_q;
    end
  end

  // State registers, FSM and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
      taps_q  <= TAPS_INIT;
      cnt_q   <= '0;
      fsm_q   <= FSM_INIT;
      valid_q <= ~HAS_WARMUP;
      busy_q  <= HAS_WARMUP;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      taps_q  <= taps_d;
      cnt_q   <= cnt_d;
      fsm_q   <= fsm_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rnd_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign rnd_o       = state_q[OUT_W-1:0];
  assign state_o     = state_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: two 8-bit instances (STEP=1/WARMUP=4
// and STEP=4/WARMUP=1) compared against a parity-based reference model.
module tb_lfsr_prng;

  localparam logic [7:0] TAPS8 = 8'hB8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: STEP=1, WARMUP=4
  logic       a_seed_valid = 1'b0;
  logic [7:0] a_seed = '0, a_taps = '0;
  logic       a_ready = 1'b0;
  logic       a_valid, a_busy;
  logic [7:0] a_rnd, a_state;

  // Instance B: STEP=4, WARMUP=1
  logic       b_seed_valid = 1'b0;
  logic [7:0] b_seed = '0, b_taps = '0;
  logic       b_ready = 1'b0;
  logic       b_valid, b_busy;
  logic [7:0] b_rnd, b_state;

  int total = 0;
  int passed = 0;
  logic [7:0] model_a, model_b;

  lfsr_prng #(
    .WIDTH(8), .OUT_W(8), .STEP(1), .SEED(8'h00), .TAPS(TAPS8), .WARMUP(4)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(a_seed_valid), .seed_i(a_seed),
    .taps_i(a_taps), .rnd_valid_o(a_valid), .rnd_ready_i(a_ready),
    .rnd_o(a_rnd), .state_o(a_state), .busy_o(a_busy)
  );

  lfsr_prng #(
    .WIDTH(8), .OUT_W(8), .STEP(4), .SEED(8'h00), .TAPS(TAPS8), .WARMUP(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(b_seed_valid), .seed_i(b_seed),
    .taps_i(b_taps), .rnd_valid_o(b_valid), .rnd_ready_i(b_ready),
    .rnd_o(b_rnd), .state_o(b_state), .busy_o(b_busy)
  );

  // Reference: n shifts, new bit is 1 when the tapped bits hold an even count of ones.
  function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] taps, input int n);
    int v;
    v = int'(s);
    for (int i = 0; i < n; i++) begin
      v = (v * 2) % 256 + ((($countones(8'(v) & taps) % 2) == 0) ? 1 : 0);
    end
    return 8'(v);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (a_state !== 8'h00) $display("FAIL reset_a_state: got %h expected 00", a_state); else passed++;
    total++; if (a_rnd !== 8'h00) $display("FAIL reset_a_rnd: got %h expected 00", a_rnd); else passed++;
    total++; if (a_valid !== 1'b0) $display("FAIL reset_a_valid: got %b expected 0", a_valid); else passed++;
    total++; if (a_busy !== 1'b1) $display("FAIL reset_a_busy: got %b expected 1", a_busy); else passed++;
    total++; if (b_state !== 8'h00) $display("FAIL reset_b_state: got %h expected 00", b_state); else passed++;
    total++; if (b_valid !== 1'b0 || b_busy !== 1'b1) $display("FAIL reset_b_flags: got valid=%b busy=%b expected 0/1", b_valid, b_busy); else passed++;
  endtask

  // Called at a negedge while reset is low; releases it and follows the warm-up.
  task automatic warmup_trace(input string tag);
    logic [7:0] exp;
    rst_n = 1'b1;
    total++; if (a_state !== 8'h00) $display("FAIL %s_start: got %h expected 00", tag, a_state); else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = ref_step(8'h00, TAPS8, k);
      total++; if (a_state !== exp) $display("FAIL %s_state[%0d]: got %h expected %h", tag, k, a_state, exp); else passed++;
      total++; if (a_valid !== (k == 4)) $display("FAIL %s_valid[%0d]: got %b expected %b", tag, k, a_valid, (k == 4)); else passed++;
      total++; if (a_busy !== (k != 4)) $display("FAIL %s_busy[%0d]: got %b expected %b", tag, k, a_busy, (k != 4)); else passed++;
      if (k == 1) begin
        exp = ref_step(8'h00, TAPS8, 4);
        total++; if (b_state !== exp || b_valid !== 1'b1 || b_busy !== 1'b0)
          $display("FAIL %s_b_after_warmup: got state=%h valid=%b busy=%b expected %h/1/0", tag, b_state, b_valid, b_busy, exp);
        else passed++;
      end
    end
    total++; if (a_rnd !== 8'h0F) $display("FAIL %s_rnd: got %h expected 0f", tag, a_rnd); else passed++;
    model_a = 8'h0F;
    model_b = 8'h0F;
  endtask

  task automatic test_handshake();
    a_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (a_rnd !== 8'h0F || a_valid !== 1'b1) $display("FAIL hold[%0d]: got rnd=%h valid=%b expected 0f/1", i, a_rnd, a_valid); else passed++;
    end
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    model_a = ref_step(model_a, TAPS8, 1);
    total++; if (a_rnd !== model_a) $display("FAIL single_fire: got %h expected %h", a_rnd, model_a); else passed++;
    @(negedge clk);
    total++; if (a_rnd !== model_a) $display("FAIL after_fire_hold: got %h expected %h", a_rnd, model_a); else passed++;
  endtask

  task automatic test_random_fire();
    logic ra, rb;
    for (int i = 0; i < 200; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      a_ready = ra;
      b_ready = rb;
      @(negedge clk);
      if (ra) model_a = ref_step(model_a, TAPS8, 1);
      if (rb) model_b = ref_step(model_b, TAPS8, 4);
      total++; if (a_rnd !== model_a || a_valid !== 1'b1) $display("FAIL rand_a[%0d]: got rnd=%h valid=%b expected %h/1", i, a_rnd, a_valid, model_a); else passed++;
      total++; if (b_state !== model_b || b_valid !== 1'b1) $display("FAIL rand_b[%0d]: got state=%h valid=%b expected %h/1", i, b_state, b_valid, model_b); else passed++;
    end
    a_ready = 1'b0;
    b_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    a_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_state !== 8'h00 || a_rnd !== 8'h00) $display("FAIL async_a_state: got state=%h rnd=%h expected 00/00", a_state, a_rnd); else passed++;
    total++; if (a_valid !== 1'b0 || a_busy !== 1'b1) $display("FAIL async_a_flags: got valid=%b busy=%b expected 0/1", a_valid, a_busy); else passed++;
    total++; if (b_state !== 8'h00 || b_busy !== 1'b1) $display("FAIL async_b: got state=%h busy=%b expected 00/1", b_state, b_busy); else passed++;
    a_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (a_state !== 8'h00) $display("FAIL async_hold: got %h expected 00", a_state); else passed++;
    warmup_trace("rewarm");
  endtask

  task automatic test_period();
    bit seen [256];
    logic [7:0] start;
    int n, distinct;
    bit saw_ff;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    start = a_state;
    total++; if (start !== model_a) $display("FAIL period_start: got %h expected %h", start, model_a); else passed++;
    seen[start] = 1'b1;
    distinct = 1;
    saw_ff = 1'b0;
    n = 0;
    a_ready = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      n++;
      model_a = ref_step(model_a, TAPS8, 1);
      total++; if (a_state !== model_a) $display("FAIL period_seq[%0d]: got %h expected %h", n, a_state, model_a); else passed++;
      if (a_state === 8'hFF) saw_ff = 1'b1;
      if (a_state === start) break;
      if (!seen[a_state]) begin
        seen[a_state] = 1'b1;
        distinct++;
      end
    end
    a_ready = 1'b0;
    total++; if (n != 255) $display("FAIL period_len: got %0d expected 255", n); else passed++;
    total++; if (distinct != 255) $display("FAIL period_distinct: got %0d expected 255", distinct); else passed++;
    total++; if (saw_ff) $display("FAIL period_no_ff: got all-ones state expected none"); else passed++;
  endtask

  task automatic test_multistep();
    total++; if (b_state !== 8'h0F) $display("FAIL multi_start: got %h expected 0f", b_state); else passed++;
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    model_b = ref_step(8'h0F, TAPS8, 1);
    model_b = ref_step(model_b, TAPS8, 1);
    model_b = ref_step(model_b, TAPS8, 1);
    model_b = ref_step(model_b, TAPS8, 1);
    total++; if (b_rnd !== model_b) $display("FAIL multi_fire: got %h expected %h", b_rnd, model_b); else passed++;
  endtask

  task automatic test_seed_load();
    logic [7:0] exp, old;
    // All-ones seed falls back to SEED; taps 0x38 gain the forced MSB (0xB8).
    a_seed_valid = 1'b1; a_seed = 8'hFF; a_taps = 8'h38; a_ready = 1'b1;
    @(negedge clk);
    a_seed_valid = 1'b0; a_ready = 1'b0;
    total++; if (a_state !== 8'h00 || a_valid !== 1'b0 || a_busy !== 1'b1)
      $display("FAIL load_ff: got state=%h valid=%b busy=%b expected 00/0/1", a_state, a_valid, a_busy);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = ref_step(8'h00, TAPS8, k);
      total++; if (a_state !== exp || a_valid !== (k == 4))
        $display("FAIL load_warm[%0d]: got state=%h valid=%b expected %h/%b", k, a_state, a_valid, exp, (k == 4));
      else passed++;
    end
    model_a = a_state === 8'h0F ? 8'h0F : ref_step(8'h00, TAPS8, 4);
    a_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      model_a = ref_step(model_a, TAPS8, 1);
      total++; if (a_state !== model_a) $display("FAIL load_taps[%0d]: got %h expected %h", i, a_state, model_a); else passed++;
    end
    // Load concurrent with a fire: consumer takes the old value, load wins.
    old = a_rnd;
    total++; if (old !== model_a || a_valid !== 1'b1) $display("FAIL concur_old: got %h valid=%b expected %h/1", old, a_valid, model_a); else passed++;
    a_seed_valid = 1'b1; a_seed = 8'h5A; a_taps = TAPS8;
    @(negedge clk);
    a_seed_valid = 1'b0; a_ready = 1'b0;
    total++; if (a_state !== 8'h5A || a_valid !== 1'b0) $display("FAIL concur_load: got state=%h valid=%b expected 5a/0", a_state, a_valid); else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = ref_step(8'h5A, TAPS8, k);
      total++; if (a_state !== exp || a_valid !== (k == 4))
        $display("FAIL concur_warm[%0d]: got state=%h valid=%b expected %h/%b", k, a_state, a_valid, exp, (k == 4));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    warmup_trace("warmup");
    test_handshake();
    test_random_fire();
    test_async_reset();
    test_period();
    test_multistep();
    test_seed_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
